// File: rtl/gamepad_events.sv
// -----------------------------------------------------------------------------
// gamepad_events
//
// Turns successive scans of four 16-button gamepads into a stream of
// per-button press/release events. The events are queued in a small
// show-ahead FIFO, and the committed held-button state is exported.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset
//   gp1..gp4       raw pad words from the shift-register reader (pad 0..3)
//   gp_data_ready  reader level; its rising edge marks a fresh, complete scan
//   ev_valid       FIFO head holds an event
//   ev_ready       consumer accepts the head event
//   ev_pad         pad index of the head event
//   ev_button      button index of the head event
//   ev_pressed     1 = press, 0 = release
//   buttons        committed held state {pad3,pad2,pad1,pad0}, pressed = 1
//   fifo_level     current FIFO occupancy
//   overrun        sticky: a pending snapshot was replaced before it was scanned
//   clr_overrun    synchronous clear of overrun
//
// Handshake: an event transfers on a rising clk edge where ev_valid and
// ev_ready are both high. ev_valid never depends on ev_ready. While ev_valid
// is high, the ev_* fields stay stable until the transfer happens. When
// ev_valid is low, the ev_* fields read 0.
//
// The FSM state is held in the named signal 'state' (IDLE/SCAN). The scan
// position is in 'idx'.
// -----------------------------------------------------------------------------
module gamepad_events #(
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter logic [15:0] BTN_MASK       = 16'h0FFF,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               gp1,
    input  logic [15:0]               gp2,
    input  logic [15:0]               gp3,
    input  logic [15:0]               gp4,
    input  logic                      gp_data_ready,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [1:0]                ev_pad,
    output logic [3:0]                ev_button,
    output logic                      ev_pressed,
    output logic [63:0]               buttons,
    output logic [LOG_FIFO_DEPTH:0]   fifo_level,
    output logic                      overrun,
    input  logic                      clr_overrun
);

    localparam logic [LOG_FIFO_DEPTH-1:0] PTR_ONE  = LOG_FIFO_DEPTH'(1);
    localparam logic [LOG_FIFO_DEPTH:0]   CNT_ONE  = (LOG_FIFO_DEPTH+1)'(1);
    localparam logic [LOG_FIFO_DEPTH:0]   CNT_FULL = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Normalised pad word: pressed = 1, masked buttons always released.
    function automatic logic [15:0] normalize(input logic [15:0] raw);
        logic [15:0] level;
        level = ACTIVE_LOW ? ~raw : raw;
        return level & BTN_MASK;
    endfunction

    // -------------------------------------------------------------------------
    // Sample detect and snapshot
    // -------------------------------------------------------------------------
    logic        ready_d;
    logic        new_sample;
    logic        pending;
    logic [63:0] snap;
    logic [63:0] sample_word;

    // ready_d resets to 0, so a level that is already high when reset
    // releases is seen as a rising edge.
    assign new_sample  = gp_data_ready & ~ready_d;
    assign sample_word = {normalize(gp4), normalize(gp3),
                          normalize(gp2), normalize(gp1)};

    // -------------------------------------------------------------------------
    // Scan FSM
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [63:0] work;
    logic [5:0]  idx;
    logic        changed;
    logic        load_work;
    logic        advance;
    logic        push;
    logic        pop;
    logic        fifo_full;

    assign changed = work[idx] ^ buttons[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_work  = 1'b0;
        advance    = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    load_work  = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!changed) begin
                    advance = 1'b1;
                end else if (!fifo_full) begin
                    push    = 1'b1;
                    advance = 1'b1;
                end
                // Changed and full: stall on this bit so no event is lost.
                if (advance && (idx == 6'd63)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Snapshot, working copy and committed state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_d <= 1'b0;
            pending <= 1'b0;
            snap    <= '0;
            overrun <= 1'b0;
            work    <= '0;
            idx     <= '0;
            buttons <= '0;
        end else begin
            ready_d <= gp_data_ready;

            // A new sample arriving as IDLE takes the old snapshot still
            // leaves pending set. No data is lost in that case.
            if (new_sample) begin
                snap    <= sample_word;
                pending <= 1'b1;
            end else if (load_work) begin
                pending <= 1'b0;
            end

            // Setting the flag has priority over clearing it.
            if (new_sample && pending && !load_work) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            if (load_work) begin
                work <= snap;
                idx  <= '0;
            end else if (advance) begin
                idx  <= idx + 6'd1;
            end

            if (push) begin
                buttons[idx] <= work[idx];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event FIFO (show-ahead)
    // -------------------------------------------------------------------------
    logic [6:0]                mem [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0] wr_ptr;
    logic [LOG_FIFO_DEPTH-1:0] rd_ptr;
    logic [6:0]                head;

    // Full uses the level before the edge. A pop in the same cycle does
    // not free a slot for a push until the following cycle.
    assign fifo_full = (fifo_level == CNT_FULL);
    assign ev_valid  = (fifo_level != '0);
    assign pop       = ev_valid & ev_ready;

    // Event word layout: {pad[1:0], button[3:0], pressed}.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {idx, work[idx]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + CNT_ONE;
                2'b01:   fifo_level <= fifo_level - CNT_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Gate the head so the fields read 0 while the FIFO is empty.
    // The storage itself is not reset.
    assign head       = ev_valid ? mem[rd_ptr] : 7'd0;
    assign ev_pad     = head[6:5];
    assign ev_button  = head[4:1];
    assign ev_pressed = head[0];

endmodule

// File: tb/tb_gamepad_events.sv
// -----------------------------------------------------------------------------
// tb_gamepad_events
//
// Testbench for gamepad_events. A behavioural model keeps the held-button
// vector and builds the list of expected events for each scan. A monitor
// checks each event as it is accepted.
// -----------------------------------------------------------------------------
module tb_gamepad_events;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] gp1 = 16'hFFFF;
    logic [15:0] gp2 = 16'hFFFF;
    logic [15:0] gp3 = 16'hFFFF;
    logic [15:0] gp4 = 16'hFFFF;
    logic        gp_data_ready = 1'b0;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [1:0]  ev_pad;
    logic [3:0]  ev_button;
    logic        ev_pressed;
    logic [63:0] buttons;
    logic [4:0]  fifo_level;
    logic        overrun;
    logic        clr_overrun = 1'b0;

    // Clock and reset
    always #5 clk = ~clk;

    gamepad_events dut (
        .clk           (clk),
        .rst           (rst_n),
        .gp1           (gp1),
        .gp2           (gp2),
        .gp3           (gp3),
        .gp4           (gp4),
        .gp_data_ready (gp_data_ready),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_pad        (ev_pad),
        .ev_button     (ev_button),
        .ev_pressed    (ev_pressed),
        .buttons       (buttons),
        .fifo_level    (fifo_level),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    // Scoreboard
    logic [6:0]  exp_q[$];      // {pad, button, pressed}
    logic [63:0] model_held = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          rand_ready_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pad bits are active low and only buttons 0..11 exist. For
    // every pad/button whose new level differs from the held level, an event
    // is expected, in pad-major, button-minor order.
    task automatic model_scan(input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3, input logic [15:0] w4);
        logic [15:0] words [4];
        words[0] = w1; words[1] = w2; words[2] = w3; words[3] = w4;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 16; b++) begin
                logic now_pressed;
                now_pressed = (b < 12) && (words[p][b] == 1'b0);
                if (now_pressed != model_held[p*16 + b]) begin
                    exp_q.push_back({2'(p), 4'(b), now_pressed});
                    model_held[p*16 + b] = now_pressed;
                end
            end
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a scan to the DUT. On return, the rising edge of
    // gp_data_ready has been registered.
    task automatic present(input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] w4);
        gp_data_ready = 1'b0;
        step();
        gp1 = w1; gp2 = w2; gp3 = w3; gp4 = w4;
        step();
        gp_data_ready = 1'b1;
        step();
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!(exp_q.size() == 0 && fifo_level == 5'd0) && c < 4000) begin
            step();
            c++;
        end
        check({tag, "_drain"}, 64'(c < 4000), 64'd1);
        repeat (70) step();
        check({tag, "_idle"}, 64'(ev_valid), 64'd0);
        check({tag, "_buttons"}, buttons, model_held);
    endtask

    // Random consumer backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) ev_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Event monitor: checks every accepted event against the queue.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            check("event_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("event", {ev_pad, ev_button, ev_pressed}, exp_q.pop_front());
            end
        end
    end

    // Directed and random stimulus
    initial begin
        logic [15:0] ra [4];
        logic [15:0] rb [4];
        logic [15:0] rc [4];

        // Reset state
        repeat (3) step();
        check("rst_ev_valid", 64'(ev_valid), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_buttons", buttons, 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_ev_fields", {ev_pad, ev_button, ev_pressed}, 64'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Press pad 0 button 3. The event is visible 5 edges after the rise
        // is registered.
        ev_ready = 1'b1;
        model_scan(16'hFFF7, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        gp_data_ready = 1'b0;
        step();
        gp1 = 16'hFFF7;
        step();
        gp_data_ready = 1'b1;
        step();                       // rise registered
        repeat (4) step();
        check("latency_e4_valid", 64'(ev_valid), 64'd0);
        step();
        check("latency_e5_valid", 64'(ev_valid), 64'd1);
        check("latency_e5_head", {ev_pad, ev_button, ev_pressed}, {2'd0, 4'd3, 1'b1});
        wait_done("press_b3");
        check("press_b3_value", buttons, 64'h8);

        // Release on the next scan
        model_scan(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        present(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done("release_b3");

        // Mask and multi-pad: only pad 0 button 0 generates an event.
        model_scan(16'h0FFE, 16'hFFFF, 16'hFFFF, 16'h7FFF);
        present(16'h0FFE, 16'hFFFF, 16'hFFFF, 16'h7FFF);
        wait_done("mask");
        check("mask_value", buttons, 64'h1);

        // Back to all released
        model_scan(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        present(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done("clear1");

        // Backpressure: 48 presses with no consumer. The FIFO fills and the
        // scan stalls at pad 1 button 4.
        ev_ready = 1'b0;
        model_scan(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        present(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (150) step();
        check("bp_level_full", 64'(fifo_level), 64'd16);
        check("bp_valid", 64'(ev_valid), 64'd1);
        check("bp_head", {ev_pad, ev_button, ev_pressed}, {2'd0, 4'd0, 1'b1});
        check("bp_stalled_buttons", buttons, 64'h0000_0000_000F_0FFF);
        check("bp_overrun_clear", 64'(overrun), 64'd0);

        // Overrun: two more scans while stalled. The second overwrites the
        // first pending snapshot.
        for (int i = 0; i < 4; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
        end
        present(ra[0], ra[1], ra[2], ra[3]);
        check("ovr_after_first", 64'(overrun), 64'd0);
        present(rb[0], rb[1], rb[2], rb[3]);
        check("ovr_after_second", 64'(overrun), 64'd1);
        step();
        check("ovr_sticky", 64'(overrun), 64'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_cleared", 64'(overrun), 64'd0);
        // Only the latest snapshot is scanned after the stalled one.
        model_scan(rb[0], rb[1], rb[2], rb[3]);
        rand_ready_en = 1'b1;
        wait_done("ovr_drain");
        check("ovr_no_reassert", 64'(overrun), 64'd0);

        // Reset during a stalled scan
        model_scan(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        present(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done("clear2");
        rand_ready_en = 1'b0;
        ev_ready = 1'b0;
        present(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (100) step();
        check("pre_reset_full", 64'(fifo_level), 64'd16);
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 64'(fifo_level), 64'd0);
        check("async_rst_valid", 64'(ev_valid), 64'd0);
        check("async_rst_buttons", buttons, 64'd0);
        check("async_rst_fields", {ev_pad, ev_button, ev_pressed}, 64'd0);
        exp_q.delete();
        model_held = '0;

        // gp_data_ready held high across reset release counts as a new sample.
        for (int i = 0; i < 4; i++) rc[i] = 16'($urandom);
        step();
        gp1 = rc[0]; gp2 = rc[1]; gp3 = rc[2]; gp4 = rc[3];
        step();
        model_scan(rc[0], rc[1], rc[2], rc[3]);
        rst_n = 1'b1;
        rand_ready_en = 1'b1;
        wait_done("ready_high_at_reset");

        // Random scans with random backpressure
        for (int n = 0; n < 12; n++) begin
            logic [15:0] w [4];
            for (int i = 0; i < 4; i++) begin
                w[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            model_scan(w[0], w[1], w[2], w[3]);
            present(w[0], w[1], w[2], w[3]);
            wait_done("rand");
        end

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
